// File: rtl/apb_timer.sv
// apb_timer: 32-bit down-counting APB timer with a registered level interrupt.
// Optional clock prescaler on CTRL[5:4] is compiled in when APB_TIMER_PRESCALE_EN is defined.
module apb_timer #(
  parameter logic [31:0] RESET_RELOAD = 32'h0000_0000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic [5:0]  PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        EXTIN,
  output logic        TIMERINT
);

`ifdef APB_TIMER_PRESCALE_EN
  localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
  localparam logic [5:0] CTRL_MASK = 6'h0F;
`endif

  logic [5:0]  ctrl;
  logic [31:0] value;
  logic [31:0] reload;
  logic        int_status;
  logic        ext_meta;
  logic        ext_sync;
  logic        ext_prev;
  logic        wr_en;
  logic        ctrl_wr;
  logic        value_wr;
  logic        reload_wr;
  logic        int_clr;
  logic        raw_tick;
  logic        tick;
  logic        count_en;
  logic        int_set;

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign ctrl_wr   = wr_en & (PADDR == 6'd0);
  assign value_wr  = wr_en & (PADDR == 6'd1);
  assign reload_wr = wr_en & (PADDR == 6'd2);
  assign int_clr   = wr_en & (PADDR == 6'd3) & PWDATA[0];

  // EXTIN synchroniser plus previous-value flop for rising-edge detection.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ext_meta <= 1'b0;
      ext_sync <= 1'b0;
      ext_prev <= 1'b0;
    end else begin
      ext_meta <= EXTIN;
      ext_sync <= ext_meta;
      ext_prev <= ext_sync;
    end
  end

  // Raw tick source: external edge wins over external gate, else free-running.
  always_comb begin
    raw_tick = 1'b1;
    if (ctrl[2]) begin
      raw_tick = ext_sync & ~ext_prev;
    end else if (ctrl[1]) begin
      raw_tick = ext_sync;
    end else begin
      raw_tick = 1'b1;
    end
  end

`ifdef APB_TIMER_PRESCALE_EN
  logic [7:0] presc_cnt;

  // Prescale counter restarts on any CTRL write and while the timer is disabled.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      presc_cnt <= 8'h00;
    end else if (ctrl_wr | ~ctrl[0]) begin
      presc_cnt <= 8'h00;
    end else if (raw_tick) begin
      presc_cnt <= presc_cnt + 8'h01;
    end
  end

  // Effective tick on wrap of the low 0/4/8 prescale bits.
  always_comb begin
    tick = 1'b0;
    case (ctrl[5:4])
      2'b00:   tick = raw_tick;
      2'b01:   tick = raw_tick & (presc_cnt[3:0] == 4'hF);
      default: tick = raw_tick & (presc_cnt == 8'hFF);
    endcase
  end
`else
  assign tick = raw_tick;
`endif

  // A VALUE write on the same edge swallows that tick entirely.
  assign count_en = ctrl[0] & tick & ~value_wr;
  assign int_set  = count_en & (value == 32'h0000_0000);

  // Register file and down counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl   <= 6'h00;
      value  <= 32'h0000_0000;
      reload <= RESET_RELOAD;
    end else begin
      if (ctrl_wr) begin
        ctrl <= PWDATA[5:0] & CTRL_MASK;
      end
      if (reload_wr) begin
        reload <= PWDATA;
      end
      if (value_wr) begin
        value <= PWDATA;
      end else if (count_en) begin
        value <= (value == 32'h0000_0000) ? reload : value - 32'h0000_0001;
      end
    end
  end

  // Sticky status (set beats clear) and registered masked interrupt.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      int_status <= 1'b0;
      TIMERINT   <= 1'b0;
    end else begin
      if (int_set) begin
        int_status <= 1'b1;
      end else if (int_clr) begin
        int_status <= 1'b0;
      end
      TIMERINT <= int_status & ctrl[3];
    end
  end

  // Combinational read mux, valid in both setup and access phases.
  always_comb begin
    PRDATA = 32'h0000_0000;
    if (PSEL & ~PWRITE) begin
      case (PADDR)
        6'd0:    PRDATA = {26'h000_0000, ctrl};
        6'd1:    PRDATA = value;
        6'd2:    PRDATA = reload;
        6'd3:    PRDATA = {31'h0000_0000, int_status};
        default: PRDATA = 32'h0000_0000;
      endcase
    end else begin
      PRDATA = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed and randomized APB traffic checked against a cycle-level
// behavioural model of the timer (honours APB_TIMER_PRESCALE_EN when defined).
module tb_apb_timer;

  localparam logic [31:0] RST_RL = 32'h0000_0005;
`ifdef APB_TIMER_PRESCALE_EN
  localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
  localparam logic [5:0] CTRL_MASK = 6'h0F;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic [5:0]  PADDR = 6'd0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        EXTIN = 1'b0;
  logic        TIMERINT;

  apb_timer #(.RESET_RELOAD(RST_RL)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .EXTIN(EXTIN), .TIMERINT(TIMERINT)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [5:0]  m_ctrl;
  logic [31:0] m_value;
  logic [31:0] m_reload;
  logic        m_int;
  logic        m_tint;
  int          m_pc;
  // EXTIN as sampled at the last three edges (e0 newest).
  logic        e0, e1, e2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 6'h00; m_value = 32'h0; m_reload = RST_RL;
    m_int = 1'b0; m_tint = 1'b0; m_pc = 0;
    e0 = 1'b0; e1 = 1'b0; e2 = 1'b0;
  endtask

  function automatic logic [31:0] mread(input logic [5:0] a);
    case (a)
      6'd0:    return {26'h0, m_ctrl};
      6'd1:    return m_value;
      6'd2:    return m_reload;
      6'd3:    return {31'h0, m_int};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: predict next state from the current inputs, clock, then check TIMERINT.
  task automatic step();
    logic        wr, raw, eff, nint, ntint;
    logic [5:0]  nctrl;
    logic [31:0] nval, nrl;
    int          npc, d;
    wr = PSEL && PENABLE && PWRITE;
    raw = m_ctrl[2] ? (e1 && !e2) : (m_ctrl[1] ? e1 : 1'b1);
`ifdef APB_TIMER_PRESCALE_EN
    d = (m_ctrl[5:4] == 2'd0) ? 1 : ((m_ctrl[5:4] == 2'd1) ? 16 : 256);
    eff = raw && ((m_pc % d) == d - 1);
    npc = ((wr && PADDR == 6'd0) || !m_ctrl[0]) ? 0 : (raw ? (m_pc + 1) % 256 : m_pc);
`else
    d = 1;
    eff = raw;
    npc = 0;
`endif
    nctrl = m_ctrl; nval = m_value; nrl = m_reload; nint = m_int;
    if (wr && PADDR == 6'd3 && PWDATA[0]) nint = 1'b0;
    if (m_ctrl[0] && eff && !(wr && PADDR == 6'd1)) begin
      if (m_value == 32'h0) begin
        nval = m_reload;
        nint = 1'b1;
      end else begin
        nval = m_value - 32'h1;
      end
    end
    if (wr && PADDR == 6'd0) nctrl = PWDATA[5:0] & CTRL_MASK;
    if (wr && PADDR == 6'd1) nval = PWDATA;
    if (wr && PADDR == 6'd2) nrl = PWDATA;
    ntint = m_int && m_ctrl[3];
    @(posedge PCLK);
    if (PRESETn) begin
      m_ctrl = nctrl; m_value = nval; m_reload = nrl; m_int = nint; m_tint = ntint; m_pc = npc;
      e2 = e1; e1 = e0; e0 = EXTIN;
    end
    #1;
    check("timerint", {31'h0, TIMERINT}, {31'h0, m_tint});
  endtask

  task automatic apb_wr(input logic [5:0] a, input logic [31:0] dat);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = dat;
    step();
    PENABLE = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [5:0] a, input string tag, output logic [31:0] dat);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #1;
    check(tag, PRDATA, mread(a));
    dat = PRDATA;
    step();
    PENABLE = 1'b1;
    #1;
    check(tag, PRDATA, mread(a));
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Hold a read of one register for n cycles, checking each cycle.
  task automatic watch(input logic [5:0] a, input int n);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    for (int i = 0; i < n; i++) begin
      #1;
      check("watch_rd", PRDATA, mread(a));
      step();
    end
    PSEL = 1'b0;
  endtask

  logic [31:0] rd;
  int          op;
  logic [31:0] exp_seq [6];

  initial begin
    model_reset();
    repeat (3) step();
    PRESETn = 1'b1;
    #1;
    check("rst_pready", {31'h0, PREADY}, 32'h1);
    check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    check("rst_timerint", {31'h0, TIMERINT}, 32'h0);
    apb_rd(6'd0, "rst_ctrl", rd);   check("rst_ctrl_k", rd, 32'h0);
    apb_rd(6'd1, "rst_value", rd);  check("rst_value_k", rd, 32'h0);
    apb_rd(6'd2, "rst_reload", rd); check("rst_reload_k", rd, RST_RL);
    apb_rd(6'd3, "rst_int", rd);    check("rst_int_k", rd, 32'h0);
    apb_rd(6'd4, "rst_off4", rd);   check("rst_off4_k", rd, 32'h0);

    // Free-running count with interrupt: VALUE 3,2,1,0,3,2...
    apb_wr(6'd2, 32'd3);
    apb_wr(6'd1, 32'd3);
    apb_wr(6'd0, 32'h9);
    exp_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 6'd1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("seq_value", PRDATA, exp_seq[i]);
      step();
    end
    PSEL = 1'b0;
    check("seq_tint_k", {31'h0, TIMERINT}, 32'h1);
    apb_wr(6'd3, 32'h1);
    watch(6'd3, 6);
    apb_rd(6'd3, "seq_int", rd);

    // External edge clocking.
    apb_wr(6'd0, 32'h0);
    apb_wr(6'd3, 32'h1);
    apb_wr(6'd2, 32'd1);
    apb_wr(6'd1, 32'd1);
    apb_wr(6'd0, 32'h5);
    for (int p = 0; p < 2; p++) begin
      EXTIN = 1'b1; watch(6'd1, 5);
      EXTIN = 1'b0; watch(6'd1, 5);
    end
    apb_rd(6'd1, "extclk_value", rd); check("extclk_value_k", rd, 32'd1);
    apb_rd(6'd3, "extclk_int", rd);   check("extclk_int_k", rd, 32'd1);

    // External gate.
    apb_wr(6'd2, 32'h20);
    apb_wr(6'd1, 32'h20);
    apb_wr(6'd0, 32'h3);
    watch(6'd1, 10);
    apb_rd(6'd1, "exten_hold", rd); check("exten_hold_k", rd, 32'h20);
    EXTIN = 1'b1;
    watch(6'd1, 8);

    // VALUE write colliding with a reload.
    apb_wr(6'd0, 32'h0);
    apb_wr(6'd2, 32'd7);
    apb_wr(6'd1, 32'd1);
    apb_wr(6'd0, 32'h1);
    apb_wr(6'd1, 32'h100);
    apb_rd(6'd1, "coll_value", rd); check("coll_value_k", rd, 32'h100);

    // INTSTATUS clear colliding with a set (RELOAD=0 sets every tick).
    apb_wr(6'd2, 32'd0);
    apb_wr(6'd1, 32'd0);
    apb_wr(6'd3, 32'h1);
    apb_rd(6'd3, "coll_int", rd); check("coll_int_k", rd, 32'h1);
    apb_wr(6'd0, 32'h0);
    apb_wr(6'd3, 32'h1);
    apb_rd(6'd3, "clr_int", rd); check("clr_int_k", rd, 32'h0);

    // Prescale field.
    EXTIN = 1'b0;
    apb_wr(6'd1, 32'd40);
    apb_wr(6'd0, 32'h11);
    watch(6'd1, 34);
    apb_rd(6'd0, "presc_ctrl", rd);
`ifdef APB_TIMER_PRESCALE_EN
    check("presc_ctrl_k", rd, 32'h11);
`else
    check("presc_ctrl_k", rd, 32'h1);
`endif

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      EXTIN = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          rd = $urandom;
          rd[0] = ($urandom_range(0, 3) != 0);
          apb_wr(6'd0, rd);
        end
        1: apb_wr(6'd1, 32'($urandom_range(0, 6)));
        2: apb_wr(6'd2, 32'($urandom_range(0, 4)));
        3: apb_wr(6'd3, 32'($urandom_range(0, 1)));
        4: apb_rd(6'($urandom_range(0, 7)), "rand_rd", rd);
        default: repeat ($urandom_range(1, 4)) step();
      endcase
    end

    // Reset in the middle of counting with the interrupt asserted.
    EXTIN = 1'b0;
    apb_wr(6'd2, 32'd0);
    apb_wr(6'd1, 32'd0);
    apb_wr(6'd0, 32'h9);
    watch(6'd3, 3);
    check("pre_rst_tint_k", {31'h0, TIMERINT}, 32'h1);
    #2;
    PRESETn = 1'b0;
    model_reset();
    #1;
    check("async_rst_tint", {31'h0, TIMERINT}, 32'h0);
    step();
    PRESETn = 1'b1;
    apb_rd(6'd0, "post_rst_ctrl", rd);   check("post_rst_ctrl_k", rd, 32'h0);
    apb_rd(6'd1, "post_rst_value", rd);  check("post_rst_value_k", rd, 32'h0);
    apb_rd(6'd2, "post_rst_reload", rd); check("post_rst_reload_k", rd, RST_RL);
    apb_rd(6'd3, "post_rst_int", rd);    check("post_rst_int_k", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
